ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver feeding the CPU's keyboard MMIO inputs (kbd_ready, kbd_overflow, kbd_data), and consuming the CPU's kbd_read_enable.
- Synchronizes the external PS/2 clock and data lines into the system clock domain.
- Deframes 11-bit scan-code frames and buffers valid bytes in a small FIFO.
- Presents the FIFO head byte with a ready/pop handshake.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO entries (8 entries by default).
TIMEOUT, 16'd50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
clk  input  1  system clock; all logic rises on posedge.
rst  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk).
ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
read_enable  input  1  pop request (CPU kbd_read_enable).
ready  output  1  FIFO non-empty.
overflow  output  1  sticky flag: at least one valid byte was dropped because the FIFO was full.
data  output  8  FIFO head byte; valid when ready=1.
frame_err  output  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset (rst=0 at posedge):
  - ready=0, overflow=0, data=8'h00, frame_err=0.
  - FIFO read/write pointers, bit counter, shift register and timeout counter all cleared.
  - Synchronizer flops set to 1 (idle bus).
  - A frame in progress is discarded.
- Synchronization:
  - ps2_clk and ps2_data each pass through 2 flops; a third flop on clk holds the previous synced clock.
  - fall = prev_sync & ~sync_clk.
  - Data is sampled from the synced ps2_data in the same cycle fall=1.
- Frame receive FSM, states IDLE, SHIFT, CHECK:
  - IDLE: on fall with data=0 (start bit), go to SHIFT with bitcnt=0. A fall with data=1 is ignored.
  - SHIFT: on each fall, shift data into shreg[9:0], LSB-first, and bitcnt++. This captures 8 data bits, the parity bit and the stop bit. After the 10th bit, go to CHECK.
  - CHECK (one cycle): the frame is valid iff (^data_bits ^ parity)==1 (odd parity) and stop==1.
    - Valid: push the byte.
    - Invalid: pulse frame_err=1 for exactly this cycle and push nothing.
    - Either way, return to IDLE.
  - Timeout: in SHIFT, a counter increments each clk without fall and resets on fall. When it reaches TIMEOUT-1, return to IDLE, clear bitcnt, and pulse frame_err.
  - Timing: the push occurs 1 clk after the stop-bit fall. ready rises on the clk after the push (3 sync flops + CHECK, about 4-5 clk after the raw ps2_clk edge).
- FIFO:
  - Pointers are DEPTH_LOG2+1 bits wide.
  - empty when the pointers are equal; full when the MSBs differ and the low bits are equal. Pointers wrap naturally.
  - data = mem[rptr] (registered memory, combinational read of the head).
  - ready = ~empty.
- Pop and push rules:
  - Pop: read_enable=1 at posedge with ready=1 advances rptr. read_enable while empty is ignored, with no pointer change.
  - Push when not full: write and advance wptr.
  - Push when full with no simultaneous pop: the byte is dropped, overflow is set to 1, and the FIFO contents are unchanged.
  - Push and pop in the same cycle: both execute, even if full beforehand. The count is unchanged and overflow is not set.
- overflow clearing: overflow stays 1 until the first accepted pop (read_enable & ready), then clears on that edge. A drop and a pop in the same cycle cannot occur (see the rule above).

Test Plan:
1. Reset then send 0x1C (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) at 10 kHz ps2_clk → frame_err never pulses; ready=1 and data=8'h1C within 6 clk of the stop-bit falling edge; a read_enable pulse → ready=0.
2. Send 0xF0 with wrong parity (1) → frame_err is a single 1-cycle pulse, ready stays 0; then send 0x1C → data=8'h1C, confirming recovery.
3. With no reads, send 9 bytes 0x01..0x09 → after 8 bytes ready=1, no overflow; the 9th sets overflow=1. Popping 8 times yields 0x01..0x08 in order; overflow clears after the first pop; ready=0 after the 8th pop.
4. With the FIFO full (8 bytes), assert read_enable in the exact CHECK cycle of a 9th valid byte 0x55 → overflow stays 0; the remaining sequence is 0x02..0x08 followed by 0x55.
5. Send a start bit plus 4 data bits, hold ps2_clk high for TIMEOUT clk → frame_err pulses once, FSM is in IDLE; a following full frame 0x2A is received correctly.
6. Drive rst=0 for one clk mid-frame (after 5 bits) with 3 bytes buffered → next clk ready=0, overflow=0, data=8'h00; a subsequent frame 0x3B is received as the only entry.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, deframes
// 11-bit scan-code frames and queues valid bytes in a small FIFO that
// the CPU drains through a ready/pop handshake.
module ps2_kbd_rx #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       read_enable,
  output logic       ready,
  output logic       overflow,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic                  clk_s1, clk_s2, clk_prev;
  logic                  dat_s1, dat_s2;
  logic                  fall;

  logic [1:0]            state;
  logic [3:0]            bit_cnt;
  logic [9:0]            shreg;
  logic [15:0]           to_cnt;
  logic                  frame_valid;
  logic                  timeout_hit;
  logic                  push;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2:0]   wptr, rptr;
  logic                  empty, full;
  logic                  pop, wr_en, drop;

  // Two-flop synchronizers for both PS/2 lines plus a history flop on the clock
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // shreg[7:0] = data bits, shreg[8] = parity, shreg[9] = stop
  assign frame_valid = (^shreg[8:0]) & shreg[9];
  assign timeout_hit = (state == SHIFT) && !fall && (to_cnt == TIMEOUT - 16'd1);
  assign push        = (state == CHECK) && frame_valid;
  assign frame_err   = ((state == CHECK) && !frame_valid) || timeout_hit;

  // Frame receive FSM: hunt for a start bit, shift in ten bits, then judge the frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 10'd0;
      to_cnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= 16'd0;
          if (fall && !dat_s2) begin
            state   <= SHIFT;
            bit_cnt <= 4'd0;
          end
        end
        SHIFT: begin
          if (fall) begin
            shreg   <= {dat_s2, shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            to_cnt  <= 16'd0;
            if (bit_cnt == 4'd9) begin
              state <= CHECK;
            end
          end else if (timeout_hit) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            to_cnt  <= 16'd0;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          bit_cnt <= 4'd0;
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= 4'd0;
          to_cnt  <= 16'd0;
        end
      endcase
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign pop   = read_enable & ~empty;
  // A simultaneous pop frees the head slot, so a push into a full FIFO still lands
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign ready = ~empty;
  assign data  = empty ? 8'h00 : mem[rptr[DEPTH_LOG2-1:0]];

  // FIFO storage: written at the tail whenever a byte is accepted
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[DEPTH_LOG2-1:0]] <= shreg[7:0];
    end
  end

  // FIFO pointers and the sticky overflow flag, cleared by the first accepted pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (pop) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: drives PS/2 frames bit by bit and
// compares popped bytes and flags against a queue-based model.
module tb_ps2_kbd_rx;

  localparam int          HALF    = 20;
  localparam int          DEPTH   = 8;
  localparam logic [15:0] TIMEOUT = 16'd200;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       read_enable;
  logic       ready;
  logic       overflow;
  logic [7:0] data;
  logic       frame_err;

  int         vec_count  = 0;
  int         fail_count = 0;
  int         ferr_count = 0;
  int         ferr_base;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  ps2_kbd_rx #(
    .DEPTH_LOG2(3),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .read_enable(read_enable),
    .ready(ready),
    .overflow(overflow),
    .data(data),
    .frame_err(frame_err)
  );

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which frame_err is high, so pulse width shows up too
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic readByte();
    logic [31:0] exp;
    logic        had;
    had = (exp_q.size() != 0);
    checkOutput("ready_before_pop", {31'd0, ready}, {31'd0, had});
    exp = had ? {24'd0, exp_q.pop_front()} : 32'h100;
    checkOutput("pop_data", {24'd0, data}, exp);
    read_enable = 1'b1;
    @(posedge clk);
    #1;
    read_enable = 1'b0;
    if (had) exp_ovf = 1'b0;
    checkOutput("overflow_after_pop", {31'd0, overflow}, {31'd0, exp_ovf});
    checkOutput("ready_after_pop", {31'd0, ready}, {31'd0, exp_q.size() != 0});
  endtask

  // Send the first nbits of a frame; optionally check ready latency or pop in the CHECK cycle
  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input int nbits,
                               input bit check_lat, input bit pop_chk);
    logic [10:0] frame;
    logic        par;
    int          waited;
    par   = ~(^b) ^ bad_par;
    frame = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      idle(HALF);
      ps2_clk = 1'b0;
      waited  = 0;
      if (i == 10 && !bad_par) begin
        if (pop_chk) begin
          idle(3);
          waited = 3;
          checkOutput("check_cycle_pop_data", {24'd0, data},
                      exp_q.size() != 0 ? {24'd0, exp_q[0]} : 32'h100);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          exp_q.push_back(b);
          read_enable = 1'b1;
          @(posedge clk);
          #1;
          read_enable = 1'b0;
          waited = 4;
        end else begin
          if (exp_q.size() < DEPTH) exp_q.push_back(b);
          else exp_ovf = 1'b1;
        end
        if (check_lat) begin
          for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            waited++;
            if (ready === 1'b1) break;
          end
          checkOutput("ready_latency", {31'd0, ready}, 32'd1);
        end
      end
      idle(HALF - waited);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    read_enable = 1'b0;
    idle(3);
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset_data", {24'd0, data}, 32'h00);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    idle(5);

    // Single good byte with latency check
    ferr_base = ferr_count;
    applyStimulus(8'h1C, 1'b0, 11, 1'b1, 1'b0);
    idle(10);
    checkOutput("t1_no_frame_err", ferr_count - ferr_base, 32'd0);
    readByte();

    // Bad parity is rejected with a single pulse, then recovery
    ferr_base = ferr_count;
    applyStimulus(8'hF0, 1'b1, 11, 1'b0, 1'b0);
    idle(10);
    checkOutput("t2_frame_err_pulse", ferr_count - ferr_base, 32'd1);
    checkOutput("t2_ready_low", {31'd0, ready}, 32'd0);
    applyStimulus(8'h1C, 1'b0, 11, 1'b0, 1'b0);
    idle(10);
    readByte();

    // Fill past capacity without reading
    for (int i = 1; i <= 8; i++) applyStimulus(i[7:0], 1'b0, 11, 1'b0, 1'b0);
    idle(10);
    checkOutput("t3_full_ready", {31'd0, ready}, 32'd1);
    checkOutput("t3_full_no_ovf", {31'd0, overflow}, 32'd0);
    applyStimulus(8'h09, 1'b0, 11, 1'b0, 1'b0);
    idle(10);
    checkOutput("t3_overflow_set", {31'd0, overflow}, {31'd0, exp_ovf});
    for (int i = 0; i < 8; i++) readByte();

    // Push and pop in the same cycle while full
    for (int i = 1; i <= 8; i++) applyStimulus(i[7:0], 1'b0, 11, 1'b0, 1'b0);
    idle(10);
    applyStimulus(8'h55, 1'b0, 11, 1'b0, 1'b1);
    idle(10);
    checkOutput("t4_no_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) readByte();

    // Partial frame abandoned by timeout
    ferr_base = ferr_count;
    applyStimulus(8'hA5, 1'b0, 5, 1'b0, 1'b0);
    idle(int'(TIMEOUT) + 20);
    checkOutput("t5_timeout_pulse", ferr_count - ferr_base, 32'd1);
    applyStimulus(8'h2A, 1'b0, 11, 1'b0, 1'b0);
    idle(10);
    checkOutput("t5_no_extra_err", ferr_count - ferr_base, 32'd1);
    readByte();

    // Reset in the middle of a frame with bytes buffered
    applyStimulus(8'h11, 1'b0, 11, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 11, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 11, 1'b0, 1'b0);
    applyStimulus(8'h77, 1'b0, 6, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    checkOutput("t6_ready_cleared", {31'd0, ready}, 32'd0);
    checkOutput("t6_overflow_cleared", {31'd0, overflow}, 32'd0);
    checkOutput("t6_data_cleared", {24'd0, data}, 32'h00);
    idle(10);
    applyStimulus(8'h3B, 1'b0, 11, 1'b0, 1'b0);
    idle(10);
    readByte();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
